// File: rtl/alu_decode_stage_pkg.sv
// alu_decode_stage_pkg
// Shared definitions for the decode and execute stages: ALU control codes,
// RV32I opcode and funct3/funct7 constants, and the packed control bundle
// that travels from decode to execute alongside the immediate.
package alu_decode_stage_pkg;

  // ALU control codes. Bit 3 set selects the signed group; 4'b0100 is the
  // only bit3=0 code and means unsigned compare.
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_OR   = 4'b1011;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SRL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_SUBU = 4'b0100;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // OP / OP-IMM funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded control fields handed to the execute stage
  typedef struct packed {
    logic [3:0] alu_cntr;
    logic       b_sel_imm;
    logic       slt_sel;
    logic [2:0] br_type;
    logic       is_branch;
    logic       is_jump;
    logic       illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_RESET = '{
    alu_cntr:  ALU_ADD,
    b_sel_imm: 1'b0,
    slt_sel:   1'b0,
    br_type:   3'b000,
    is_branch: 1'b0,
    is_jump:   1'b0,
    illegal:   1'b0
  };

  // Only the base and alternate funct7 encodings exist in RV32I
  function automatic logic funct7_ok(input logic [6:0] f7);
    return (f7 == F7_BASE) || (f7 == F7_ALT);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Purely combinational RV32I decoder producing the ALU control bundle and the
// sign-extended immediate for one instruction word.
// Ports:
//   instr  in   32     RV32I instruction word
//   ctrl   out  bundle alu_cntr, b_sel_imm, slt_sel, br_type, class flags
//   imm    out  WIDTH  immediate, sign-extended from bit 31
module alu_ctrl_decode
  import alu_decode_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output ctrl_bundle_t     ctrl,
  output logic [WIDTH-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decode the instruction class, ALU operation and 32-bit immediate.
  always_comb begin
    ctrl    = CTRL_RESET;
    imm_raw = '0;
    case (opcode)
      OPC_OP: begin
        if (!funct7_ok(funct7)) begin
          ctrl.illegal = 1'b1;
        end else begin
          case (funct3)
            F3_ADD:  ctrl.alu_cntr = funct7[5] ? ALU_SUB : ALU_ADD;
            F3_SLL:  ctrl.alu_cntr = ALU_SLL;
            F3_SLT:  begin ctrl.alu_cntr = ALU_SUB;  ctrl.slt_sel = 1'b1; end
            F3_SLTU: begin ctrl.alu_cntr = ALU_SUBU; ctrl.slt_sel = 1'b1; end
            F3_XOR:  ctrl.alu_cntr = ALU_XOR;
            F3_SR:   ctrl.alu_cntr = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   ctrl.alu_cntr = ALU_OR;
            F3_AND:  ctrl.alu_cntr = ALU_AND;
            default: ctrl.alu_cntr = ALU_ADD;
          endcase
        end
      end
      OPC_OP_IMM: begin
        ctrl.b_sel_imm = 1'b1;
        imm_raw        = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          F3_ADD:  ctrl.alu_cntr = ALU_ADD;
          F3_SLT:  begin ctrl.alu_cntr = ALU_SUB;  ctrl.slt_sel = 1'b1; end
          F3_SLTU: begin ctrl.alu_cntr = ALU_SUBU; ctrl.slt_sel = 1'b1; end
          F3_XOR:  ctrl.alu_cntr = ALU_XOR;
          F3_OR:   ctrl.alu_cntr = ALU_OR;
          F3_AND:  ctrl.alu_cntr = ALU_AND;
          // Shift-immediates carry shamt in the low bits and funct7 above it
          F3_SLL: begin
            imm_raw = {27'b0, instr[24:20]};
            if (!funct7_ok(funct7)) ctrl.illegal = 1'b1;
            else                    ctrl.alu_cntr = ALU_SLL;
          end
          F3_SR: begin
            imm_raw = {27'b0, instr[24:20]};
            if (!funct7_ok(funct7)) ctrl.illegal = 1'b1;
            else                    ctrl.alu_cntr = instr[30] ? ALU_SRA : ALU_SRL;
          end
          default: ctrl.alu_cntr = ALU_ADD;
        endcase
      end
      OPC_BRANCH: begin
        imm_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
        case (funct3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE: begin
            ctrl.alu_cntr  = ALU_SUB;
            ctrl.is_branch = 1'b1;
            ctrl.br_type   = funct3;
          end
          F3_BLTU, F3_BGEU: begin
            ctrl.alu_cntr  = ALU_SUBU;
            ctrl.is_branch = 1'b1;
            ctrl.br_type   = funct3;
          end
          // funct3 010/011 are not branch encodings
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.b_sel_imm = 1'b1;
        imm_raw        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        ctrl.b_sel_imm = 1'b1;
        imm_raw        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_JALR: begin
        ctrl.b_sel_imm = 1'b1;
        ctrl.is_jump   = 1'b1;
        imm_raw        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_JAL: begin
        ctrl.b_sel_imm = 1'b1;
        ctrl.is_jump   = 1'b1;
        imm_raw        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      end
      OPC_AUIPC, OPC_LUI: begin
        ctrl.b_sel_imm = 1'b1;
        imm_raw        = {instr[31:12], 12'b0};
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Illegal words still flow downstream but as a harmless ADD
    if (ctrl.illegal) begin
      ctrl.alu_cntr = ALU_ADD;
      ctrl.slt_sel  = 1'b0;
    end
  end

  assign imm = WIDTH'($signed(imm_raw));

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Decode pipeline stage: one output register holding the decoded bundle,
// with a valid/ready handshake on both sides and a flush for branch redirect.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_instr the RV32I word
//   flush                 drop held bundle and the word offered this cycle
//   out_valid/out_ready   downstream handshake
//   alu_cntr, imm, b_sel_imm, slt_sel, br_type, is_branch, is_jump, illegal
//                         registered decode results
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_cntr,
  output logic [WIDTH-1:0] imm,
  output logic             b_sel_imm,
  output logic             slt_sel,
  output logic [2:0]       br_type,
  output logic             is_branch,
  output logic             is_jump,
  output logic             illegal
);

  ctrl_bundle_t     dec_ctrl;
  logic [WIDTH-1:0] dec_imm;
  ctrl_bundle_t     ctrl_q;
  logic [WIDTH-1:0] imm_q;
  logic             valid_q;
  logic             accept;

  alu_ctrl_decode #(.WIDTH(WIDTH)) u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  // Ready whenever the register is empty or being drained this cycle
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: flush beats everything except reset; a stalled bundle
  // simply keeps its contents because no branch below updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RESET;
      imm_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      imm_q   <= dec_imm;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign alu_cntr  = ctrl_q.alu_cntr;
  assign imm       = imm_q;
  assign b_sel_imm = ctrl_q.b_sel_imm;
  assign slt_sel   = ctrl_q.slt_sel;
  assign br_type   = ctrl_q.br_type;
  assign is_branch = ctrl_q.is_branch;
  assign is_jump   = ctrl_q.is_jump;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
// Self-checking bench: a table of instruction vectors with hand-derived
// decode results, a handshake model with a scoreboard queue, and directed
// sequences for stall, flush and reset-during-stall.
module tb_alu_decode_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_cntr;
  logic [WIDTH-1:0] imm;
  logic             b_sel_imm;
  logic             slt_sel;
  logic [2:0]       br_type;
  logic             is_branch;
  logic             is_jump;
  logic             illegal;

  alu_decode_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_cntr  (alu_cntr),
    .imm       (imm),
    .b_sel_imm (b_sel_imm),
    .slt_sel   (slt_sel),
    .br_type   (br_type),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [31:0] imm;
    bit          imm_care;
    logic        bsel;
    logic        slt;
    logic        br;
    logic [2:0]  brt;
    logic        jmp;
    logic        ill;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];
  vec_t cur_exp;
  vec_t sb[$];
  vec_t front;

  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  logic m_valid = 1'b0;
  logic exp_ready;

  function automatic vec_t mk(input string name, input logic [31:0] instr,
                              input logic [3:0] alu, input logic [31:0] imm_v,
                              input bit imm_care, input logic bsel,
                              input logic slt, input logic br,
                              input logic [2:0] brt, input logic jmp,
                              input logic ill);
    vec_t v;
    v.name = name; v.instr = instr; v.alu = alu; v.imm = imm_v;
    v.imm_care = imm_care; v.bsel = bsel; v.slt = slt; v.br = br;
    v.brt = brt; v.jmp = jmp; v.ill = ill;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passes++;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_instr = v.instr;
    in_valid = 1'b1;
    cur_exp  = v;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".alu_cntr"},  32'(alu_cntr),  32'h8);
    checkOutput({tag, ".imm"},       imm,            32'd0);
    checkOutput({tag, ".flags"},
                32'({b_sel_imm, slt_sel, is_branch, is_jump, illegal}), 32'd0);
    checkOutput({tag, ".br_type"},   32'(br_type),   32'd0);
  endtask

  // Handshake model and scoreboard, sampled on the falling edge: checks the
  // current outputs, then predicts what the next rising edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = !m_valid || out_ready;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        if (sb.size() == 0) begin
          checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          front = sb[0];
          checkOutput({front.name, ".alu_cntr"}, 32'(alu_cntr), 32'(front.alu));
          if (front.imm_care)
            checkOutput({front.name, ".imm"}, imm, front.imm);
          checkOutput({front.name, ".b_sel_imm"}, 32'(b_sel_imm), 32'(front.bsel));
          checkOutput({front.name, ".slt_sel"}, 32'(slt_sel), 32'(front.slt));
          checkOutput({front.name, ".is_branch"}, 32'(is_branch), 32'(front.br));
          if (front.br)
            checkOutput({front.name, ".br_type"}, 32'(br_type), 32'(front.brt));
          checkOutput({front.name, ".is_jump"}, 32'(is_jump), 32'(front.jmp));
          checkOutput({front.name, ".illegal"}, 32'(illegal), 32'(front.ill));
        end
      end
      if (rst || flush) begin
        m_valid = 1'b0;
        sb.delete();
      end else begin
        if (m_valid && out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_valid = 1'b0;
        end
        if (in_valid && exp_ready) begin
          sb.push_back(cur_exp);
          m_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //              name     instr         alu    imm           care bs slt br brt   jmp ill
    vecs[0]  = mk("ADDI",   32'hFFB00093, 4'b1000, 32'hFFFFFFFB, 1, 1, 0, 0, 3'b000, 0, 0);
    vecs[1]  = mk("SLTU",   32'h0020B1B3, 4'b0100, 32'h0,        0, 0, 1, 0, 3'b000, 0, 0);
    vecs[2]  = mk("BGEU",   32'h0020F463, 4'b0100, 32'h00000008, 1, 0, 0, 1, 3'b111, 0, 0);
    vecs[3]  = mk("SRAI",   32'h4030D093, 4'b1111, 32'h00000003, 1, 1, 0, 0, 3'b000, 0, 0);
    vecs[4]  = mk("SUB",    32'h402081B3, 4'b1100, 32'h0,        0, 0, 0, 0, 3'b000, 0, 0);
    vecs[5]  = mk("AND",    32'h0020F1B3, 4'b1001, 32'h0,        0, 0, 0, 0, 3'b000, 0, 0);
    vecs[6]  = mk("SLTI",   32'hFFF0A193, 4'b1100, 32'hFFFFFFFF, 1, 1, 1, 0, 3'b000, 0, 0);
    vecs[7]  = mk("LUI",    32'h123452B7, 4'b1000, 32'h12345000, 1, 1, 0, 0, 3'b000, 0, 0);
    vecs[8]  = mk("SW",     32'hFE20AE23, 4'b1000, 32'hFFFFFFFC, 1, 1, 0, 0, 3'b000, 0, 0);
    vecs[9]  = mk("JAL",    32'hFF9FF0EF, 4'b1000, 32'hFFFFFFF8, 1, 1, 0, 0, 3'b000, 1, 0);
    vecs[10] = mk("JALR",   32'h00008067, 4'b1000, 32'h00000000, 1, 1, 0, 0, 3'b000, 1, 0);
    vecs[11] = mk("OPC7F",  32'h0000007F, 4'b1000, 32'h0,        0, 0, 0, 0, 3'b000, 0, 1);
    vecs[12] = mk("BADF7",  32'h022081B3, 4'b1000, 32'h0,        0, 0, 0, 0, 3'b000, 0, 1);
    vecs[13] = mk("SRL",    32'h0020D1B3, 4'b1110, 32'h0,        0, 0, 0, 0, 3'b000, 0, 0);
    vecs[14] = mk("BLT",    32'h0020C463, 4'b1100, 32'h00000008, 1, 0, 0, 1, 3'b100, 0, 0);
    vecs[15] = mk("AUIPC",  32'hFFFFF097, 4'b1000, 32'hFFFFF000, 1, 1, 0, 0, 3'b000, 0, 0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cur_exp   = vecs[0];

    repeat (2) nextCycle();
    checkResetValues("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Back-to-back table run with the consumer always ready
    $display("[TB] table run, %0d vectors", NVEC);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      nextCycle();
    end
    in_valid = 1'b0;
    repeat (2) nextCycle();

    // Stall: held bundle must stay put and block the next word
    $display("[TB] stall sequence");
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    nextCycle();
    applyStimulus(vecs[3]);
    repeat (3) nextCycle();
    checkOutput("stall.in_ready", 32'(in_ready), 32'd0);
    checkOutput("stall.imm_held", imm, 32'hFFFFFFFB);
    out_ready = 1'b1;
    nextCycle();
    in_valid = 1'b0;
    checkOutput("stall.new_bundle_alu", 32'(alu_cntr), 32'hF);
    nextCycle();

    // Flush with a held bundle and a word on offer
    $display("[TB] flush sequence");
    out_ready = 1'b0;
    applyStimulus(vecs[4]);
    nextCycle();
    applyStimulus(vecs[5]);
    flush = 1'b1;
    nextCycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
    // Flush with an empty register drops the offered word too
    applyStimulus(vecs[7]);
    flush = 1'b1;
    nextCycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_empty.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (2) nextCycle();

    // Reset while a bundle is stalled
    $display("[TB] reset during stall");
    out_ready = 1'b0;
    applyStimulus(vecs[9]);
    nextCycle();
    in_valid = 1'b0;
    nextCycle();
    rst = 1'b1;
    nextCycle();
    checkResetValues("mid_stall_reset");
    rst = 1'b0;
    checkOutput("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    applyStimulus(vecs[6]);
    nextCycle();
    in_valid = 1'b0;
    repeat (3) nextCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
- REQ-001: Parameter WIDTH, default 32, datapath and immediate width.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset; synchronous, active-high.
- REQ-004: in_valid  input  1  instruction word present.
- REQ-005: in_ready  output  1  stage accepts the word this cycle.
- REQ-006: in_instr  input  32  RV32I instruction word.
- REQ-007: flush  input  1  discard held and incoming instruction (branch redirect).
- REQ-008: out_valid  output  1  decoded bundle present.
- REQ-009: out_ready  input  1  execute stage consumes the bundle this cycle.
- REQ-010: alu_cntr  output  4  ALU operation code for the execute stage.
- REQ-011: imm  output  WIDTH  sign-extended immediate.
- REQ-012: b_sel_imm  output  1  operand B is imm (1) or rs2 (0).
- REQ-013: slt_sel  output  1  writeback takes the ALU less-than flag, zero-extended, instead of the ALU result.
- REQ-014: br_type  output  3  funct3 of a branch; valid only when is_branch.
- REQ-015: is_branch, is_jump, illegal  output  1 each  instruction class flags.

Function
- REQ-016: alu_cntr encoding: bit3=1 signed group {000 ADD, 001 AND, 010 XOR, 011 OR, 100 SUB/compare, 101 SLL, 110 SRL, 111 SRA}; 4'b0100 unsigned compare; all other bit3=0 codes are never emitted.
- REQ-017: OP/OP-IMM mapping: ADD/ADDI 1000; SUB 1100; AND 1001; XOR 1010; OR 1011; SLL 1101; SRL 1110; SRA 1111; SLT/SLTI 1100 with slt_sel=1; SLTU/SLTIU 0100 with slt_sel=1.
- REQ-018: Branch mapping: BEQ/BNE/BLT/BGE 1100; BLTU/BGEU 0100; b_sel_imm=0; is_branch=1; br_type=funct3.
- REQ-019: LOAD, STORE, JALR, AUIPC, LUI, JAL map to 1000 with b_sel_imm=1; JAL and JALR set is_jump=1.
- REQ-020: Immediates are formed per I, S, B, U and J formats and sign-extended from bit 31 to WIDTH.
- REQ-021: Shift-immediates take imm[4:0]=shamt; SRAI is selected by instr[30]=1.
- REQ-022: Unknown opcode, or funct7 not 0000000/0100000 where it applies, sets illegal=1 and alu_cntr=1000; the bundle still propagates.
- REQ-023: One output register stage; latency is exactly one cycle from in_valid&&in_ready to out_valid.
- REQ-024: in_ready = !out_valid || out_ready, combinational; it has no dependence on in_valid.
- REQ-025: When in_valid&&in_ready, all outputs load the new decode and out_valid=1.
- REQ-026: When out_valid&&out_ready and no new input is accepted, out_valid clears next cycle.
- REQ-027: When out_valid&&!out_ready, every output holds stable until the bundle is consumed.
- REQ-028: flush has priority: out_valid=0 next cycle regardless of in_valid or out_ready, and the word offered that cycle is dropped.
- REQ-029: Back-to-back: with out_ready held high, one bundle is emitted per cycle with no bubbles.

Reset
- REQ-030: While rst=1: out_valid=0; alu_cntr=4'b1000; imm=0; b_sel_imm, slt_sel, is_branch, is_jump and illegal=0; br_type=0.
- REQ-031: in_ready=1 on the first cycle after reset deasserts.
- REQ-032: Reset asserted mid-stall discards the held bundle.

Structure
- REQ-033: Shared package holds the alu_cntr code constants, RV32I opcode constants and funct3 branch constants; the execute stage uses the same package.
- REQ-034: One combinational sub-module, alu_ctrl_decode (instr in, bundle out); the top holds only the handshake and output register.

Verification
- REQ-035: ADDI x1,x0,-5 (0xFFB00093) -> next cycle out_valid=1, alu_cntr=1000, imm=0xFFFFFFFB, b_sel_imm=1.
- REQ-036: SLTU (0x0020B1B3), then BGEU (0x0020F463) back-to-back with out_ready=1 -> alu_cntr=0100 on both cycles; slt_sel=1 then is_branch=1 with br_type=111.
- REQ-037: SRAI x1,x1,3 (0x4030D093) -> alu_cntr=1111, imm[4:0]=3.
- REQ-038: Bundle valid with out_ready=0 for 3 cycles and new in_valid -> in_ready=0, outputs unchanged; out_ready=1 -> new bundle the following cycle.
- REQ-039: flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle; opcode 0x7F -> illegal=1.
